// File: rtl/clink_rec_seq_if.sv
// rtl/clink_rec_seq_if.sv - bus between clink_rec_seq and its MVM source, LUT and datapath
//
// Purpose: groups every non-clock/reset signal of clink_rec_seq.
// Signals:
//   start       run request (sampled only while idle)
//   pre_act     signed Q.12 gate pre-activation, qualified by pre_vld/pre_rdy
//   gate_id     gate being fetched: 0=I 1=G 2=F 3=O
//   rec_output  cell magnitude from the datapath, valid during O_RECV
//   lut_addr    sigmoid LUT read address, sampled when lut_rd=1
//   mvm_sel     LUT segment: 0=+sat 1=positive 2=negative mirrored 3=-sat
//   curr_s      datapath state code, iter_n cell index
//   busy/done   run in progress / one-cycle completion pulse
interface clink_rec_seq_if;
  logic        start;
  logic [15:0] pre_act;
  logic        pre_vld;
  logic        pre_rdy;
  logic [1:0]  gate_id;
  logic [9:0]  rec_output;
  logic [9:0]  lut_addr;
  logic        lut_rd;
  logic [1:0]  mvm_sel;
  logic [2:0]  curr_s;
  logic [2:0]  iter_n;
  logic        busy;
  logic        done;

  modport master (
    output start, pre_act, pre_vld, rec_output,
    input  pre_rdy, gate_id, lut_addr, lut_rd, mvm_sel, curr_s, iter_n, busy, done
  );

  modport slave (
    input  start, pre_act, pre_vld, rec_output,
    output pre_rdy, gate_id, lut_addr, lut_rd, mvm_sel, curr_s, iter_n, busy, done
  );
endinterface

// File: rtl/clink_rec_seq.sv
// rtl/clink_rec_seq.sv - recurrent-cell sequencer and sigmoid-LUT lookup front end
//
// Purpose: steps the datapath through I/G/F/O/C per cell for N_CELL cells,
// fetches each gate pre-activation over pre_vld/pre_rdy, classifies it into a
// LUT segment and issues a registered LUT read so the data is ready in the
// gate's EXEC cycle. The cell magnitude is looked up the same way for tanh(c).
// Ports:
//   clock    system clock
//   reset_n  asynchronous active-low reset
//   bus      clink_rec_seq_if.slave (see interface file for signal list)
module clink_rec_seq #(
  parameter int N_CELL     = 5,
  parameter int LUT_SIZE   = 1024,
  parameter int ADDR_SHIFT = 5
) (
  input  logic           clock,
  input  logic           reset_n,
  clink_rec_seq_if.slave bus
);

  localparam logic [16:0] LUT_W   = 17'(LUT_SIZE);
  localparam logic [4:0]  SH_F    = 5'(ADDR_SHIFT);
  localparam logic [4:0]  SH_G    = 5'(ADDR_SHIFT - 1);
  localparam logic [2:0]  LAST_IT = 3'(N_CELL - 1);
  localparam logic [2:0]  END_IT  = 3'(N_CELL);

  localparam logic [2:0] CS_IDLE   = 3'b000;
  localparam logic [2:0] CS_CRECV  = 3'b101;
  localparam logic [2:0] CS_FINISH = 3'b110;
  localparam logic [2:0] CS_STALL  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LWAIT, ST_EXEC, ST_CWAIT, ST_CRECV, ST_FINISH
  } state_t;

  state_t      state_q;
  logic [1:0]  gate_q;
  logic [2:0]  iter_q;
  logic        pre_rdy_q;
  logic [9:0]  lut_addr_q;
  logic        lut_rd_q;
  logic [1:0]  sel_q;
  logic [2:0]  curr_s_q;
  logic        busy_q;
  logic        done_q;

  // Segment classification of the incoming pre-activation. The magnitude is
  // 17 bits wide so that -32768 maps to +32768 instead of wrapping. Gate G
  // uses one less shift because tanh(x) is read as 2*sigmoid(2x)-1.
  logic        neg;
  logic [16:0] mag;
  logic [16:0] idx;
  logic [4:0]  sh;
  logic        sat;

  always_comb begin
    neg = bus.pre_act[15];
    mag = neg ? (17'd0 - {1'b1, bus.pre_act}) : {1'b0, bus.pre_act};
    sh  = (gate_q == 2'd1) ? SH_G : SH_F;
    idx = mag >> sh;
    sat = (idx >= LUT_W);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gate_q     <= 2'd0;
      iter_q     <= 3'd0;
      pre_rdy_q  <= 1'b0;
      lut_addr_q <= 10'd0;
      lut_rd_q   <= 1'b0;
      sel_q      <= 2'd0;
      curr_s_q   <= CS_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      lut_rd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          curr_s_q <= CS_IDLE;
          if (bus.start) begin
            state_q   <= ST_FETCH;
            busy_q    <= 1'b1;
            iter_q    <= 3'd0;
            gate_q    <= 2'd0;
            pre_rdy_q <= 1'b1;
            curr_s_q  <= CS_STALL;
          end
        end
        ST_FETCH: begin
          if (bus.pre_vld && pre_rdy_q) begin
            state_q   <= ST_LWAIT;
            pre_rdy_q <= 1'b0;
            lut_rd_q  <= 1'b1;
            if (sat) begin
              sel_q      <= neg ? 2'd3 : 2'd0;
              lut_addr_q <= 10'd0;
            end else begin
              sel_q      <= neg ? 2'd2 : 2'd1;
              lut_addr_q <= idx[9:0];
            end
          end
        end
        ST_LWAIT: begin
          // LUT sampled the address at this edge; its data is valid in EXEC.
          state_q  <= ST_EXEC;
          curr_s_q <= {1'b0, gate_q} + 3'd1;
        end
        ST_EXEC: begin
          curr_s_q <= CS_STALL;
          if (gate_q == 2'd3) begin
            // Reuse the LUT for tanh(c); segment select is left untouched.
            state_q    <= ST_CWAIT;
            lut_addr_q <= bus.rec_output;
            lut_rd_q   <= 1'b1;
          end else begin
            state_q   <= ST_FETCH;
            gate_q    <= gate_q + 2'd1;
            pre_rdy_q <= 1'b1;
          end
        end
        ST_CWAIT: begin
          state_q  <= ST_CRECV;
          curr_s_q <= CS_CRECV;
        end
        ST_CRECV: begin
          if (iter_q < LAST_IT) begin
            state_q   <= ST_FETCH;
            iter_q    <= iter_q + 3'd1;
            gate_q    <= 2'd0;
            pre_rdy_q <= 1'b1;
            curr_s_q  <= CS_STALL;
          end else begin
            state_q  <= ST_FINISH;
            iter_q   <= END_IT;
            curr_s_q <= CS_FINISH;
          end
        end
        ST_FINISH: begin
          state_q  <= ST_IDLE;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          iter_q   <= 3'd0;
          gate_q   <= 2'd0;
          curr_s_q <= CS_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          curr_s_q <= CS_IDLE;
        end
      endcase
    end
  end

  assign bus.pre_rdy  = pre_rdy_q;
  assign bus.gate_id  = gate_q;
  assign bus.lut_addr = lut_addr_q;
  assign bus.lut_rd   = lut_rd_q;
  assign bus.mvm_sel  = sel_q;
  assign bus.curr_s   = curr_s_q;
  assign bus.iter_n   = iter_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_clink_rec_seq.sv
// tb/tb_clink_rec_seq.sv - scoreboard bench for clink_rec_seq
module tb_clink_rec_seq;

  logic clock;
  logic reset_n;

  clink_rec_seq_if u_if ();

  clink_rec_seq #(.N_CELL(5), .LUT_SIZE(1024), .ADDR_SHIFT(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] pa;
    logic [1:0]  sel;
    logic [9:0]  addr;
  } vec_t;

  typedef struct {
    logic [9:0] addr;
    logic [1:0] sel;
  } sb_t;

  vec_t       vec [20];
  logic [9:0] rec_tbl [5];
  logic [2:0] pat [14];
  sb_t        sbq [$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int stall_left = 0;
  bit rand_mode = 1'b1;
  logic [2:0] prev_cs = 3'd0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    // slot = cell*4 + gate (I,G,F,O); expectations worked out by hand
    vec[0]  = '{16'h0800, 2'd1, 10'd64};
    vec[1]  = '{16'h0800, 2'd1, 10'd128};
    vec[2]  = '{16'hF800, 2'd2, 10'd64};
    vec[3]  = '{16'h8000, 2'd3, 10'd0};
    vec[4]  = '{16'h0000, 2'd1, 10'd0};
    vec[5]  = '{16'h4000, 2'd0, 10'd0};
    vec[6]  = '{16'h7FFF, 2'd1, 10'd1023};
    vec[7]  = '{16'hFFFF, 2'd2, 10'd0};
    vec[8]  = '{16'hC000, 2'd2, 10'd512};
    vec[9]  = '{16'h3FFF, 2'd1, 10'd1023};
    vec[10] = '{16'h4000, 2'd1, 10'd512};
    vec[11] = '{16'h8001, 2'd2, 10'd1023};
    vec[12] = '{16'h8000, 2'd3, 10'd0};
    vec[13] = '{16'hC000, 2'd3, 10'd0};
    vec[14] = '{16'h0020, 2'd1, 10'd1};
    vec[15] = '{16'hFFE0, 2'd2, 10'd1};
    vec[16] = '{16'h001F, 2'd1, 10'd0};
    vec[17] = '{16'h0010, 2'd1, 10'd1};
    vec[18] = '{16'h7FE0, 2'd1, 10'd1023};
    vec[19] = '{16'h8020, 2'd2, 10'd1023};
    rec_tbl = '{10'h155, 10'h2AA, 10'h3FF, 10'h000, 10'h001};
    pat = '{3'd7, 3'd7, 3'd1, 3'd7, 3'd7, 3'd2, 3'd7, 3'd7, 3'd3,
            3'd7, 3'd7, 3'd4, 3'd7, 3'd5};
  end

  // Stimulus driver: presents the pre-activation for the requested slot and
  // pushes the expected LUT request at each accepted handshake.
  always @(negedge clock) begin : drv
    int it;
    int g;
    int slot;
    if (rand_mode) begin
      u_if.pre_act    = 16'($urandom);
      u_if.pre_vld    = 1'($urandom);
      u_if.rec_output = 10'($urandom);
    end else begin
      it   = int'(u_if.iter_n);
      g    = int'(u_if.gate_id);
      slot = (it < 5) ? it * 4 + g : 0;
      u_if.pre_act    = vec[slot].pa;
      u_if.rec_output = (it < 5) ? rec_tbl[it] : 10'd0;
      if (u_if.pre_rdy && it == 2 && g == 1 && stall_left > 0) begin
        u_if.pre_vld = 1'b0;
        stall_left--;
        chk("bp_curr_s", int'(u_if.curr_s), 7);
        chk("bp_gate_id", int'(u_if.gate_id), 1);
      end else begin
        u_if.pre_vld = 1'b1;
      end
      if (u_if.pre_vld && u_if.pre_rdy && reset_n && it < 5) begin
        sbq.push_back('{vec[slot].addr, vec[slot].sel});
        if (g == 3) sbq.push_back('{rec_tbl[it], vec[slot].sel});
      end
    end
  end

  // Monitor: pops the scoreboard on every LUT read strobe.
  always @(negedge clock) begin : mon
    sb_t e;
    if (!reset_n) begin
      sbq.delete();
      prev_cs = 3'd0;
    end else begin
      if (u_if.lut_rd) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_lut_addr", int'(u_if.lut_addr), int'(e.addr));
          chk("sb_mvm_sel", int'(u_if.mvm_sel), int'(e.sel));
        end
      end
      if (u_if.curr_s inside {[3'd1:3'd6]})
        chk("exec_dup", int'(u_if.curr_s == prev_cs), 0);
      prev_cs = u_if.curr_s;
      if (u_if.done) done_cnt++;
    end
  end

  task automatic do_run(input string nm, input int exp_cyc, input bit poke, input bit exact);
    logic [2:0] cs_log [$];
    logic [2:0] it_log [$];
    logic [2:0] ex [$];
    int cyc, got, errs, c_ph, ck_it, d0, j;
    d0 = done_cnt;
    c_ph = 0;
    ck_it = 0;
    @(negedge clock);
    u_if.start = 1'b1;
    @(negedge clock);
    u_if.start = 1'b0;
    cyc = 1;
    got = 0;
    chk({nm, "_first_curr_s"}, int'(u_if.curr_s), 7);
    chk({nm, "_first_iter_n"}, int'(u_if.iter_n), 0);
    chk({nm, "_first_gate_id"}, int'(u_if.gate_id), 0);
    chk({nm, "_first_busy"}, int'(u_if.busy), 1);
    chk({nm, "_first_pre_rdy"}, int'(u_if.pre_rdy), 1);
    while (cyc <= 400) begin
      cs_log.push_back(u_if.curr_s);
      it_log.push_back(u_if.iter_n);
      if (c_ph == 1) begin
        chk({nm, "_c_lut_addr"}, int'(u_if.lut_addr), int'(rec_tbl[ck_it]));
        chk({nm, "_c_lut_rd"}, int'(u_if.lut_rd), 1);
        chk({nm, "_c_wait_cs"}, int'(u_if.curr_s), 7);
        c_ph = 2;
      end else if (c_ph == 2) begin
        chk({nm, "_c_recv_cs"}, int'(u_if.curr_s), 5);
        chk({nm, "_c_mvm_sel"}, int'(u_if.mvm_sel), int'(vec[ck_it * 4 + 3].sel));
        c_ph = 0;
      end else if (u_if.curr_s == 3'd4 && u_if.iter_n < 3'd5) begin
        ck_it = int'(u_if.iter_n);
        c_ph = 1;
      end
      if (u_if.done) begin
        got = cyc;
        break;
      end
      u_if.start = poke && (cyc == 20);
      @(negedge clock);
      cyc++;
    end
    u_if.start = 1'b0;
    chk({nm, "_done_cycle"}, got, exp_cyc);
    repeat (4) @(negedge clock);
    chk({nm, "_done_count"}, done_cnt - d0, 1);
    chk({nm, "_idle_busy"}, int'(u_if.busy), 0);
    chk({nm, "_idle_curr_s"}, int'(u_if.curr_s), 0);
    // Sequence of non-stall codes must be 1..5 per cell then FINISH.
    errs = 0;
    foreach (cs_log[i]) if (cs_log[i] != 3'd7 && cs_log[i] != 3'd0) ex.push_back(cs_log[i]);
    if (ex.size() != 26) errs++;
    for (int i = 0; i < ex.size() && i < 26; i++) begin
      j = (i < 25) ? (i % 5) + 1 : 6;
      if (int'(ex[i]) != j) errs++;
      if (j == 6 && int'(it_log[cs_log.size() - 2]) != 5) errs++;
    end
    chk({nm, "_exec_order"}, errs, 0);
    if (exact) begin
      errs = (cs_log.size() == 72) ? 0 : 1;
      for (int c = 1; c <= cs_log.size(); c++) begin
        if (c <= 70) begin
          if (cs_log[c-1] != pat[(c-1) % 14] || int'(it_log[c-1]) != (c-1) / 14) errs++;
        end else if (c == 71) begin
          if (cs_log[c-1] != 3'd6 || it_log[c-1] != 3'd5) errs++;
        end else if (c == 72) begin
          if (cs_log[c-1] != 3'd0 || it_log[c-1] != 3'd0) errs++;
        end else begin
          errs++;
        end
      end
      chk({nm, "_exact_seq"}, errs, 0);
    end
  endtask

  function automatic logic [23:0] all_out();
    return {u_if.pre_rdy, u_if.gate_id, u_if.lut_addr, u_if.lut_rd, u_if.mvm_sel,
            u_if.curr_s, u_if.iter_n, u_if.busy, u_if.done};
  endfunction

  initial begin : main
    int errs;
    int n;
    reset_n = 1'b0;
    u_if.start = 1'b0;
    errs = 0;
    repeat (6) begin
      @(negedge clock);
      u_if.start = 1'($urandom);
      if (all_out() != 24'd0) errs++;
    end
    chk("reset_outputs_zero", errs, 0);
    u_if.start = 1'b0;
    rand_mode = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_reset_curr_s", int'(u_if.curr_s), 0);
    chk("post_reset_busy", int'(u_if.busy), 0);

    // Plain run with a start pulse injected mid-run (must be ignored).
    do_run("run_plain", 72, 1'b1, 1'b1);

    // Backpressure: 3 cycles without pre_vld in FETCH of gate G, cell 2.
    stall_left = 3;
    do_run("run_bp", 75, 1'b0, 1'b0);
    chk("bp_stalls_used", stall_left, 0);

    // Reset dropped during G_RECV of cell 3.
    @(negedge clock);
    u_if.start = 1'b1;
    @(negedge clock);
    u_if.start = 1'b0;
    n = 0;
    while (!(u_if.curr_s == 3'd2 && u_if.iter_n == 3'd3) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("abort_reached_g_recv_c3", int'(n < 300), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs_zero_now", int'(all_out()), 0);
    repeat (2) @(negedge clock);
    chk("abort_outputs_zero_held", int'(all_out()), 0);
    reset_n = 1'b1;
    errs = 0;
    repeat (4) begin
      @(negedge clock);
      if (u_if.curr_s != 3'd0 || u_if.busy) errs++;
    end
    chk("abort_stays_idle", errs, 0);
    do_run("run_rerun", 72, 1'b0, 1'b1);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
